mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter per line, giving name, default and meaning:
- TIMEOUT_CYCLES, 16, max BUSY cycles without mem_ready_i before abort.
REQ-002 The block SHALL have one port per line, giving name, direction, width and meaning:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  EX/MEM stage holds a valid instruction.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request (never asserted together with MemRead_i).
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- stall_o  out  1  holds the pipeline while an access is outstanding.
- rdata_o  out  32  extended load data, to the writeback data input.
- done_o  out  1  one-cycle pulse: access completed.
- misalign_o  out  1  one-cycle pulse: misaligned access rejected.
- err_o  out  1  one-cycle pulse: illegal funct3 or timeout.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word address {addr[31:2],2'b00}.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  memory read word.
- mem_ready_i  in  1  memory completes the request this cycle.

Function
REQ-003 start SHALL be valid_i & (MemRead_i | MemWrite_i); start SHALL be sampled only in IDLE.
REQ-004 The FSM SHALL have two states, IDLE and BUSY; IDLE->BUSY on a legal, aligned start; BUSY->IDLE on mem_ready_i or on timeout.
REQ-005 In the accept cycle, addr, funct3, wdata and we SHALL be captured; mem_req_o SHALL be registered and asserted from the first BUSY cycle.
REQ-006 mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL stay stable throughout BUSY until mem_ready_i is sampled high.
REQ-007 stall_o SHALL be combinational: (IDLE & legal aligned start) | (BUSY & ~mem_ready_i).
REQ-008 On BUSY & mem_ready_i, rdata_o SHALL be registered (extended data for loads, unchanged for stores), done_o SHALL pulse in the following cycle, and the next start SHALL be accepted in that same cycle.
REQ-009 Minimum latency SHALL be accept cycle + one BUSY cycle (mem_ready_i in the first BUSY cycle).
REQ-010 Byte enables and store lanes SHALL be:
- B: be = 1<<addr[1:0], data = {4{wdata[7:0]}}.
- H: be = addr[1] ? 1100 : 0011, data = {2{wdata[15:0]}}.
- W: be = 1111.
REQ-011 Loads SHALL select the byte or half at addr[1:0] and sign-extend for B/H or zero-extend for BU/HU; W SHALL pass through.
REQ-012 A misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) SHALL raise no request and no stall, and SHALL pulse misalign_o in the next cycle.
REQ-013 An illegal funct3 (011, 110, 111, or BU/HU on a store) SHALL raise no request and SHALL pulse err_o in the next cycle.
REQ-014 The timeout counter SHALL clear on accept and increment each BUSY cycle without ready; on reaching TIMEOUT_CYCLES, mem_req_o SHALL drop, err_o SHALL pulse, rdata_o SHALL be 0, done_o SHALL not pulse, and the state SHALL return to IDLE.
REQ-015 mem_ready_i outside BUSY SHALL be ignored.

Reset
REQ-016 On rst, the state SHALL be IDLE and the counter 0, and every output SHALL be 0 on the next edge (rdata_o=0, mem_be_o=0000).
REQ-017 A reset during BUSY SHALL drop mem_req_o at the next edge, with no done_o or err_o pulse.

Structure
REQ-018 A shared package SHALL hold the funct3 encodings, the IDLE/BUSY state enum and the default TIMEOUT_CYCLES.
REQ-019 A combinational sub-module load_extend SHALL perform lane select and sign/zero extension (REQ-011).

Verification
REQ-020 LB at addr 0x103, mem_rdata_i=0x80FF_1234, ready in the first BUSY cycle -> rdata_o=0xFFFF_FF80, done_o pulses, stall_o high for 1 cycle.
REQ-021 SH at addr 0x202, wdata_i=0x0000_ABCD, ready after 3 BUSY cycles -> mem_be_o=1100, mem_wdata_o=0xABCD_ABCD, mem_addr_o=0x200, all held stable for 3 cycles.
REQ-022 LW at addr 0x101 -> no mem_req_o, stall_o=0, misalign_o pulses once.
REQ-023 LHU at 0x400, ready never asserted, TIMEOUT_CYCLES=16 -> err_o pulses after 16 BUSY cycles, mem_req_o drops, rdata_o=0.
REQ-024 Back-to-back SW then LBU, with rst asserted in the second BUSY -> first access completes, second aborts, all outputs 0 after the reset edge.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings, state type and lane helpers for the memory access unit
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        return size == 2'b00 ? 4'b0001 << lane :
               size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        return size == 2'b00 ? {4{wdata[7:0]}} :
               size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the addressed byte/half of a read word and sign- or zero-extends it
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    // lane select, then extend by size; bit 2 of funct3 marks the unsigned variants
    always_comb begin
        b    = word[8*lane +: 8];
        h    = lane[1] ? word[31:16] : word[15:0];
        sx   = ~funct3[2];
        data = funct3[1:0] == 2'b00 ? {{24{sx & b[7]}}, b} :
               funct3[1:0] == 2'b01 ? {{16{sx & h[15]}}, h} : word;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: two-state load/store sequencer between the EX/MEM stage and a ready-handshake memory
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic [31:0]   ext;
    logic          start, legal, mis, accept;

    assign start  = valid_i & (MemRead_i | MemWrite_i);
    assign legal  = (funct3_i inside {F3_B, F3_H, F3_W}) | (~MemWrite_i & (funct3_i inside {F3_BU, F3_HU}));
    assign mis    = (funct3_i[1:0] == 2'b01 & addr_i[0]) | (funct3_i[1:0] == 2'b10 & |addr_i[1:0]);
    assign accept = state == IDLE & start & legal & ~mis;
    assign stall_o = accept | (state == BUSY & ~mem_ready_i);

    load_extend u_ext (
        .word   (mem_rdata_i),
        .lane   (lane_q),
        .funct3 (f3_q),
        .data   (ext)
    );

    // request sequencing: capture on accept, hold while busy, retire on ready or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= '0;
            lane_q      <= '0;
            rdata_o     <= '0;
            done_o      <= 1'b0;
            misalign_o  <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            err_o      <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    state       <= BUSY;
                    cnt         <= '0;
                    f3_q        <= funct3_i;
                    lane_q      <= addr_i[1:0];
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= MemWrite_i;
                    mem_addr_o  <= {addr_i[31:2], 2'b00};
                    mem_be_o    <= byte_en(funct3_i[1:0], addr_i[1:0]);
                    mem_wdata_o <= store_lanes(funct3_i[1:0], wdata_i);
                end else if (start & ~legal) begin
                    err_o <= 1'b1;
                end else if (start & mis) begin
                    misalign_o <= 1'b1;
                end
            end else if (mem_ready_i | cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state       <= IDLE;
                done_o      <= mem_ready_i;
                err_o       <= ~mem_ready_i;
                rdata_o     <= ~mem_ready_i ? '0 : mem_we_o ? rdata_o : ext;
                mem_req_o   <= 1'b0;
                mem_we_o    <= 1'b0;
                mem_be_o    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for the memory access unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        done_o, misalign_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .misalign_o  (misalign_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        valid_i    = 1'b1;
        MemRead_i  = rd;
        MemWrite_i = wr;
        funct3_i   = f3;
        addr_i     = a;
        wdata_i    = wd;
        #1;
    endtask

    task automatic idle();
        valid_i    = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word, input logic [31:0] exp);
        req(1'b1, 1'b0, f3, a, 32'h0);
        tick();
        idle();
        mem_ready_i = 1'b1;
        mem_rdata_i = word;
        tick();
        mem_ready_i = 1'b0;
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_rdata"}, rdata_o, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        funct3_i    = 3'b000;
        addr_i      = '0;
        wdata_i     = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst = 1'b0;
        tick();

        // LB 0x103, ready in first busy cycle
        req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_stall_accept", 32'(stall_o), 32'd1);
        tick();
        idle();
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h80FF_1234;
        #1;
        chk("lb_req", 32'(mem_req_o), 32'd1);
        chk("lb_we", 32'(mem_we_o), 32'd0);
        chk("lb_be", 32'(mem_be_o), 32'h8);
        chk("lb_addr", mem_addr_o, 32'h100);
        chk("lb_stall_busy", 32'(stall_o), 32'd0);
        tick();
        mem_ready_i = 1'b0;
        chk("lb_done", 32'(done_o), 32'd1);
        chk("lb_rdata", rdata_o, 32'hFFFF_FF80);
        chk("lb_req_drop", 32'(mem_req_o), 32'd0);
        tick();
        chk("lb_done_once", 32'(done_o), 32'd0);

        // SH 0x202, three busy cycles without ready
        req(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
        tick();
        idle();
        wdata_i = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            chk("sh_req", 32'(mem_req_o), 32'd1);
            chk("sh_we", 32'(mem_we_o), 32'd1);
            chk("sh_be", 32'(mem_be_o), 32'hC);
            chk("sh_wdata", mem_wdata_o, 32'hABCD_ABCD);
            chk("sh_addr", mem_addr_o, 32'h200);
            chk("sh_stall", 32'(stall_o), 32'd1);
            tick();
        end
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h1357_9BDF;
        #1;
        chk("sh_stall_ready", 32'(stall_o), 32'd0);
        tick();
        mem_ready_i = 1'b0;
        chk("sh_done", 32'(done_o), 32'd1);
        chk("sh_rdata_kept", rdata_o, 32'hFFFF_FF80);
        tick();

        // LW misaligned
        req(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        chk("lw_mis_stall", 32'(stall_o), 32'd0);
        tick();
        idle();
        chk("lw_mis_pulse", 32'(misalign_o), 32'd1);
        chk("lw_mis_req", 32'(mem_req_o), 32'd0);
        tick();
        chk("lw_mis_once", 32'(misalign_o), 32'd0);

        // illegal funct3: BU on a store, and 011 load
        req(1'b0, 1'b1, 3'b100, 32'h10, 32'h0);
        tick();
        idle();
        chk("sbu_err", 32'(err_o), 32'd1);
        chk("sbu_req", 32'(mem_req_o), 32'd0);
        req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        tick();
        idle();
        chk("f3_011_err", 32'(err_o), 32'd1);
        tick();
        chk("err_once", 32'(err_o), 32'd0);

        // load extension variants
        quick_load("lh", 3'b001, 32'h002, 32'h8001_1234, 32'hFFFF_8001);
        quick_load("lhu", 3'b101, 32'h000, 32'h1234_F00F, 32'h0000_F00F);
        quick_load("lbu", 3'b100, 32'h001, 32'h0000_AB00, 32'h0000_00AB);
        quick_load("lw", 3'b010, 32'h008, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // LHU 0x400 with no ready: timeout
        req(1'b1, 1'b0, 3'b101, 32'h400, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            chk("to_req", 32'(mem_req_o), 32'd1);
            chk("to_err_early", 32'(err_o), 32'd0);
            tick();
        end
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_req_drop", 32'(mem_req_o), 32'd0);
        chk("to_rdata", rdata_o, 32'd0);
        chk("to_done", 32'(done_o), 32'd0);

        // ready while idle is ignored
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        chk("idle_ready_done", 32'(done_o), 32'd0);
        tick();

        // SW then LBU back to back, reset in second busy cycle of the LBU
        req(1'b0, 1'b1, 3'b010, 32'h300, 32'h1122_3344);
        tick();
        chk("sw_wdata", mem_wdata_o, 32'h1122_3344);
        chk("sw_be", 32'(mem_be_o), 32'hF);
        mem_ready_i = 1'b1;
        req(1'b1, 1'b0, 3'b100, 32'h305, 32'h0);
        tick();
        mem_ready_i = 1'b0;
        #1;
        chk("sw_done", 32'(done_o), 32'd1);
        chk("lbu_b2b_stall", 32'(stall_o), 32'd1);
        tick();
        idle();
        chk("lbu_b2b_req", 32'(mem_req_o), 32'd1);
        chk("lbu_b2b_be", 32'(mem_be_o), 32'h2);
        chk("lbu_b2b_addr", mem_addr_o, 32'h304);
        tick();
        rst = 1'b1;
        tick();
        chk("rb_req", 32'(mem_req_o), 32'd0);
        chk("rb_done", 32'(done_o), 32'd0);
        chk("rb_err", 32'(err_o), 32'd0);
        chk("rb_be", 32'(mem_be_o), 32'd0);
        chk("rb_rdata", rdata_o, 32'd0);
        chk("rb_stall", 32'(stall_o), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_done", 32'(done_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
